// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
//
// Shared constants for the 1-to-4 stream demultiplexer.
//   NUM_CH     : number of output channels
//   SEL_W      : width of a channel index (select / round-robin pointer)
//   MODE_ADDR  : MODE value for routing by the S address input
//   MODE_RR    : MODE value for routing by the internal round-robin pointer
//   onehot_sel : channel index -> one-hot channel mask
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int   NUM_CH    = 4;
    localparam int   SEL_W     = 2;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Expand a channel index into a one-hot mask of NUM_CH bits.
    function automatic logic [NUM_CH-1:0] onehot_sel(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// ---------------------------------------------------------------------------
// demux_chan_reg
//
// Single-entry holding register for one output channel of the demux.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset; clears data and valid
//   load      : write din into the slot this edge
//   din       : incoming data word
//   ready     : downstream consumer accepts the held word this edge
//   dout      : held data word (keeps its last value after a drain)
//   valid     : slot holds a word not yet taken by the consumer
//   slot_free : slot can take a new word this edge (empty, or draining now)
// ---------------------------------------------------------------------------
module demux_chan_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         slot_free
);

    logic [W-1:0] dout_q;
    logic [W-1:0] dout_d;
    logic         valid_q;
    logic         valid_d;

    // A full slot whose consumer is ready empties on this edge, so it can
    // take a new word at the same time without a bubble.
    assign slot_free = ~valid_q | ready;

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (load) begin
            // A load wins over a simultaneous drain: the old word leaves,
            // the new word arrives, valid never drops.
            dout_d  = din;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            // Data is deliberately left in place; only the flag clears.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;

endmodule

// File: rtl/demux_1x4_nbit_stream.sv
// ---------------------------------------------------------------------------
// demux_1x4_nbit_stream
//
// Registered 1-to-4 demultiplexer with valid/ready handshaking. One n-bit
// input stream is routed into four single-entry output channels, either by
// the S address (MODE=0) or by an internal round-robin pointer (MODE=1).
//
// Ports:
//   CLK      : clock, rising edge
//   RST      : asynchronous active-high reset
//   D        : input data word
//   S        : channel address used when MODE=0
//   MODE     : 0 = addressed by S, 1 = round-robin via PTR
//   IN_VALID : producer presents a word on D
//   IN_READY : selected channel can take a word this cycle
//   Y0..Y3   : channel output registers
//   VALID    : per-channel output valid, bit k belongs to Yk
//   READY    : per-channel consumer ready, bit k belongs to Yk
//   PTR      : current round-robin pointer
// ---------------------------------------------------------------------------
module demux_1x4_nbit_stream
    import demux_pkg::*;
#(
    parameter int n = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [n-1:0]      D,
    input  logic [SEL_W-1:0]  S,
    input  logic              MODE,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [n-1:0]      Y0,
    output logic [n-1:0]      Y1,
    output logic [n-1:0]      Y2,
    output logic [n-1:0]      Y3,
    output logic [NUM_CH-1:0] VALID,
    input  logic [NUM_CH-1:0] READY,
    output logic [SEL_W-1:0]  PTR
);

    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  ptr_d;
    logic              accept;
    logic              in_ready;
    logic [NUM_CH-1:0] load_vec;
    logic [NUM_CH-1:0] slot_free_vec;
    logic [NUM_CH-1:0] valid_vec;
    logic [n-1:0]      dout_arr [NUM_CH];

    // Routing, handshake and pointer advance. MODE and S act in the same
    // cycle; IN_READY deliberately ignores IN_VALID so the producer may
    // look at it before committing a word.
    always_comb begin
        sel      = (MODE == MODE_RR) ? ptr_q : S;
        in_ready = slot_free_vec[sel];
        accept   = IN_VALID & in_ready;
        load_vec = accept ? onehot_sel(sel) : '0;
        ptr_d    = ptr_q;
        // The pointer only moves on an accepted round-robin word; a stalled
        // channel therefore blocks the stream instead of being skipped.
        if (accept && (MODE == MODE_RR)) begin
            ptr_d = ptr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            demux_chan_reg #(
                .W (n)
            ) u_chan (
                .clk       (CLK),
                .rst       (RST),
                .load      (load_vec[gi]),
                .din       (D),
                .ready     (READY[gi]),
                .dout      (dout_arr[gi]),
                .valid     (valid_vec[gi]),
                .slot_free (slot_free_vec[gi])
            );
        end
    endgenerate

    assign IN_READY = in_ready;
    assign VALID    = valid_vec;
    assign PTR      = ptr_q;
    assign Y0       = dout_arr[0];
    assign Y1       = dout_arr[1];
    assign Y2       = dout_arr[2];
    assign Y3       = dout_arr[3];

endmodule

// File: tb/tb_demux_1x4_nbit_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1x4_nbit_stream
//
// Directed, table-driven bench for demux_1x4_nbit_stream with n=4. Each table
// row drives one cycle of inputs and gives the IN_READY seen before the edge
// plus VALID, PTR and {Y3,Y2,Y1,Y0} after the edge. Rows run as one
// continuous sequence; a hand-written sequence afterwards covers async reset.
// ---------------------------------------------------------------------------
module tb_demux_1x4_nbit_stream;

    localparam int N     = 4;
    localparam int NVEC  = 27;

    logic         clk;
    logic         rst;
    logic [N-1:0] d;
    logic [1:0]   s;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] y0, y1, y2, y3;
    logic [3:0]   valid;
    logic [3:0]   ready;
    logic [1:0]   ptr;

    int n_checks;
    int n_pass;

    typedef struct {
        logic        mode;
        logic [1:0]  s;
        logic [3:0]  d;
        logic        iv;
        logic [3:0]  rdy;
        logic        exp_ir;
        logic [3:0]  exp_valid;
        logic [1:0]  exp_ptr;
        logic [15:0] exp_y;
    } vec_t;

    vec_t vecs [NVEC];

    demux_1x4_nbit_stream #(
        .n (N)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .D        (d),
        .S        (s),
        .MODE     (mode),
        .IN_VALID (in_valid),
        .IN_READY (in_ready),
        .Y0       (y0),
        .Y1       (y1),
        .Y2       (y2),
        .Y3       (y3),
        .VALID    (valid),
        .READY    (ready),
        .PTR      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic m, input logic [1:0] sv, input logic [3:0] dv,
                                input logic iv, input logic [3:0] rdy, input logic eir,
                                input logic [3:0] ev, input logic [1:0] ep, input logic [15:0] ey);
        vec_t v;
        v.mode = m; v.s = sv; v.d = dv; v.iv = iv; v.rdy = rdy;
        v.exp_ir = eir; v.exp_valid = ev; v.exp_ptr = ep; v.exp_y = ey;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] got,
                         input logic [15:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s step %0d: got %h want %h", name, idx, got, want);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0; d = '0; s = '0; mode = 1'b0; in_valid = 1'b0; ready = '0;

        //                mode s  d     iv rdy      ir   valid    ptr y{3,2,1,0}
        // Addressed loads with all consumers stalled, then a blocked fifth word.
        vecs[0]  = mk(1'b0, 2'd0, 4'h3, 1, 4'b0000, 1, 4'b0001, 2'd0, 16'h0003);
        vecs[1]  = mk(1'b0, 2'd1, 4'h5, 1, 4'b0000, 1, 4'b0011, 2'd0, 16'h0053);
        vecs[2]  = mk(1'b0, 2'd2, 4'h9, 1, 4'b0000, 1, 4'b0111, 2'd0, 16'h0953);
        vecs[3]  = mk(1'b0, 2'd3, 4'hC, 1, 4'b0000, 1, 4'b1111, 2'd0, 16'hC953);
        vecs[4]  = mk(1'b0, 2'd1, 4'hF, 1, 4'b0000, 0, 4'b1111, 2'd0, 16'hC953);
        // ch2 drains and reloads on the same edge: valid stays set.
        vecs[5]  = mk(1'b0, 2'd2, 4'hA, 1, 4'b0100, 1, 4'b1111, 2'd0, 16'hCA53);
        // No input: drains only, data held.
        vecs[6]  = mk(1'b0, 2'd0, 4'h0, 0, 4'b1011, 1, 4'b0100, 2'd0, 16'hCA53);
        vecs[7]  = mk(1'b0, 2'd0, 4'h0, 0, 4'b0100, 1, 4'b0000, 2'd0, 16'hCA53);
        // Round-robin, all ready, D=1..6, pointer wraps.
        vecs[8]  = mk(1'b1, 2'd0, 4'h1, 1, 4'b1111, 1, 4'b0001, 2'd1, 16'hCA51);
        vecs[9]  = mk(1'b1, 2'd0, 4'h2, 1, 4'b1111, 1, 4'b0010, 2'd2, 16'hCA21);
        vecs[10] = mk(1'b1, 2'd0, 4'h3, 1, 4'b1111, 1, 4'b0100, 2'd3, 16'hC321);
        vecs[11] = mk(1'b1, 2'd0, 4'h4, 1, 4'b1111, 1, 4'b1000, 2'd0, 16'h4321);
        vecs[12] = mk(1'b1, 2'd0, 4'h5, 1, 4'b1111, 1, 4'b0001, 2'd1, 16'h4325);
        vecs[13] = mk(1'b1, 2'd0, 4'h6, 1, 4'b1111, 1, 4'b0010, 2'd2, 16'h4365);
        // Fill with consumers stalled until PTR=1 points at a full channel.
        vecs[14] = mk(1'b1, 2'd0, 4'h7, 1, 4'b0000, 1, 4'b0110, 2'd3, 16'h4765);
        vecs[15] = mk(1'b1, 2'd0, 4'h8, 1, 4'b0000, 1, 4'b1110, 2'd0, 16'h8765);
        vecs[16] = mk(1'b1, 2'd0, 4'h9, 1, 4'b0000, 1, 4'b1111, 2'd1, 16'h8769);
        // Round-robin stall: ch1 full and not ready blocks everything.
        vecs[17] = mk(1'b1, 2'd0, 4'hB, 1, 4'b0000, 0, 4'b1111, 2'd1, 16'h8769);
        vecs[18] = mk(1'b1, 2'd0, 4'hB, 1, 4'b1101, 0, 4'b0010, 2'd1, 16'h8769);
        vecs[19] = mk(1'b1, 2'd0, 4'hB, 1, 4'b0010, 1, 4'b0010, 2'd2, 16'h87B9);
        // Mode switch: PTR=3 survives an addressed word, then targets ch3.
        vecs[20] = mk(1'b1, 2'd0, 4'hD, 1, 4'b1111, 1, 4'b0100, 2'd3, 16'h8DB9);
        vecs[21] = mk(1'b0, 2'd0, 4'hE, 1, 4'b1111, 1, 4'b0001, 2'd3, 16'h8DBE);
        vecs[22] = mk(1'b1, 2'd0, 4'h1, 1, 4'b1111, 1, 4'b1000, 2'd0, 16'h1DBE);
        // Set up VALID=0101, PTR=2 for the reset sequence.
        vecs[23] = mk(1'b1, 2'd0, 4'h2, 1, 4'b1000, 1, 4'b0001, 2'd1, 16'h1DB2);
        vecs[24] = mk(1'b1, 2'd0, 4'h7, 1, 4'b0000, 1, 4'b0011, 2'd2, 16'h1D72);
        vecs[25] = mk(1'b0, 2'd2, 4'h0, 0, 4'b0010, 1, 4'b0001, 2'd2, 16'h1D72);
        vecs[26] = mk(1'b0, 2'd2, 4'h7, 1, 4'b0000, 1, 4'b0101, 2'd2, 16'h1772);

        // Initial reset.
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_valid", -1, 16'(valid), 16'h0000);
        check("reset_ptr",   -1, 16'(ptr),   16'h0000);
        check("reset_y",     -1, {y3, y2, y1, y0}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            mode = vecs[i].mode; s = vecs[i].s; d = vecs[i].d;
            in_valid = vecs[i].iv; ready = vecs[i].rdy;
            #1;
            check("in_ready", i, 16'(in_ready), 16'(vecs[i].exp_ir));
            @(posedge clk);
            #1;
            check("valid", i, 16'(valid), 16'(vecs[i].exp_valid));
            check("ptr",   i, 16'(ptr),   16'(vecs[i].exp_ptr));
            check("y",     i, {y3, y2, y1, y0}, vecs[i].exp_y);
            $display("step %0d: mode=%0d s=%0d d=%h iv=%0d rdy=%b -> ir=%0d valid=%b ptr=%0d y=%h",
                     i, vecs[i].mode, vecs[i].s, vecs[i].d, vecs[i].iv, vecs[i].rdy,
                     in_ready, valid, ptr, {y3, y2, y1, y0});
        end

        // Asynchronous reset mid-cycle with VALID=0101, PTR=2: outputs clear
        // before the next rising edge and stay cleared while RST is held.
        @(negedge clk);
        in_valid = 1'b0; ready = '0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 100, 16'(valid), 16'h0000);
        check("async_rst_ptr",   100, 16'(ptr),   16'h0000);
        check("async_rst_y",     100, {y3, y2, y1, y0}, 16'h0000);
        in_valid = 1'b1; d = 4'h6; mode = 1'b0; s = 2'd1;
        @(posedge clk);
        #1;
        check("rst_hold_valid", 101, 16'(valid), 16'h0000);
        check("rst_hold_y",     101, {y3, y2, y1, y0}, 16'h0000);
        $display("reset: valid=%b ptr=%0d y=%h", valid, ptr, {y3, y2, y1, y0});
        @(negedge clk);
        rst = 1'b0;
        // First word after reset routes normally.
        @(posedge clk);
        #1;
        check("post_rst_valid", 102, 16'(valid), 16'h0002);
        check("post_rst_y",     102, {y3, y2, y1, y0}, 16'h0060);
        $display("post-reset word: valid=%b y=%h", valid, {y3, y2, y1, y0});
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
